// File: rtl/if_stage_pkg.sv
// Shared types, widths and constants for the instruction-fetch stage.
package if_stage_pkg;

    localparam int unsigned inst_addr_w = 32;
    localparam int unsigned inst_w      = 32;
    localparam int unsigned stall_w     = 6;

    localparam logic [inst_w-1:0] zero_word    = 32'h0000_0000;
    localparam logic              chip_enable  = 1'b1;
    localparam logic              chip_disable = 1'b0;
    localparam logic              rstn_enable  = 1'b0;
    localparam logic              rstn_disable = 1'b1;

    // Stall vector bit positions.
    localparam int unsigned stall_pc_bit = 0;
    localparam int unsigned stall_if_bit = 1;
    localparam int unsigned stall_id_bit = 2;

    typedef struct packed {
        logic [inst_addr_w-1:0] pc;
        logic [inst_w-1:0]      inst;
        logic                   misalign;
    } if_id_t;

    function automatic if_id_t if_id_bubble();
        if_id_t b;
        b.pc       = zero_word;
        b.inst     = zero_word;
        b.misalign = 1'b0;
        return b;
    endfunction

    function automatic logic is_misaligned(input logic [inst_addr_w-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter, ROM chip-enable and pending-redirect register.
module if_stage_pc_reg
    import if_stage_pkg::*;
#(
    parameter logic [inst_addr_w-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned            PC_STEP  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_pc,
    input  logic                   flush,
    input  logic [inst_addr_w-1:0] new_pc,
    input  logic                   branch_flag_i,
    input  logic [inst_addr_w-1:0] branch_target_address_i,
    output logic                   ce,
    output logic [inst_addr_w-1:0] pc
);

    logic                   ce_nxt;
    logic [inst_addr_w-1:0] pc_nxt;
    logic                   pend_valid;
    logic                   pend_valid_nxt;
    logic [inst_addr_w-1:0] pend_target;
    logic [inst_addr_w-1:0] pend_target_nxt;

    // Next PC by priority: flush, stall (capture redirect), branch, pending, step.
    always_comb begin
        ce_nxt          = chip_enable;
        pc_nxt          = pc;
        pend_valid_nxt  = pend_valid;
        pend_target_nxt = pend_target;
        if (ce == chip_disable) begin
            pc_nxt = RESET_PC;
        end else if (flush) begin
            pc_nxt         = new_pc;
            pend_valid_nxt = 1'b0;
        end else if (stall_pc) begin
            if (branch_flag_i) begin
                pend_valid_nxt  = 1'b1;
                pend_target_nxt = branch_target_address_i;
            end
        end else if (branch_flag_i) begin
            pc_nxt         = branch_target_address_i;
            pend_valid_nxt = 1'b0;
        end else if (pend_valid) begin
            pc_nxt         = pend_target;
            pend_valid_nxt = 1'b0;
        end else begin
            pc_nxt = pc + inst_addr_w'(PC_STEP);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == rstn_enable) begin
            ce          <= chip_disable;
            pc          <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_target <= zero_word;
        end else begin
            ce          <= ce_nxt;
            pc          <= pc_nxt;
            pend_valid  <= pend_valid_nxt;
            pend_target <= pend_target_nxt;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC generation plus the IF/ID pipeline latch.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [inst_addr_w-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned            PC_STEP  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [stall_w-1:0]     stall,
    input  logic                   flush,
    input  logic [inst_addr_w-1:0] new_pc,
    input  logic                   branch_flag_i,
    input  logic [inst_addr_w-1:0] branch_target_address_i,
    input  logic [inst_w-1:0]      rom_inst_i,
    output logic                   rom_ce_o,
    output logic [inst_addr_w-1:0] rom_addr_o,
    output logic [inst_addr_w-1:0] id_pc_o,
    output logic [inst_w-1:0]      id_inst_o,
    output logic                   id_misalign_o
);

    if_id_t if_id_q;
    if_id_t if_id_nxt;
    logic   unused_stall;

    // Later pipeline stages' stall bits are not consumed here.
    assign unused_stall = ^stall[stall_w-1:stall_id_bit+1];

    if_stage_pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP)
    ) u_pc_reg (
        .clk                     (clk),
        .rst                     (rst),
        .stall_pc                (stall[stall_pc_bit]),
        .flush                   (flush),
        .new_pc                  (new_pc),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .ce                      (rom_ce_o),
        .pc                      (rom_addr_o)
    );

    // IF/ID latch: bubble on flush or when IF stalls while ID runs.
    always_comb begin
        if_id_nxt = if_id_q;
        if (flush) begin
            if_id_nxt = if_id_bubble();
        end else if (stall[stall_if_bit] && !stall[stall_id_bit]) begin
            if_id_nxt = if_id_bubble();
        end else if (!stall[stall_if_bit]) begin
            if_id_nxt.pc       = rom_addr_o;
            if_id_nxt.inst     = (rom_ce_o == chip_enable) ? rom_inst_i : zero_word;
            if_id_nxt.misalign = is_misaligned(rom_addr_o);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (rst == rstn_enable) begin
            if_id_q <= if_id_bubble();
        end else begin
            if_id_q <= if_id_nxt;
        end
    end

    assign id_pc_o       = if_id_q.pc;
    assign id_inst_o     = if_id_q.inst;
    assign id_misalign_o = if_id_q.misalign;

endmodule
